// File: rtl/tamagotchi_pkg.sv
// Shared constants and types for the pet's button front end.
package tamagotchi_pkg;

  localparam int ACT_W   = 3;
  localparam int NUM_BTN = 8;

  localparam logic [ACT_W-1:0] ACT_FEED   = 3'd0;
  localparam logic [ACT_W-1:0] ACT_PLAY   = 3'd1;
  localparam logic [ACT_W-1:0] ACT_HEAL   = 3'd2;
  localparam logic [ACT_W-1:0] ACT_CLEAN  = 3'd3;
  localparam logic [ACT_W-1:0] ACT_SLEEP  = 3'd4;
  localparam logic [ACT_W-1:0] ACT_SOCIAL = 3'd5;
  localparam logic [ACT_W-1:0] ACT_RSVD6  = 3'd6;
  localparam logic [ACT_W-1:0] ACT_RSVD7  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OFFER,
    ST_COOLDOWN
  } state_t;

  // Lowest set bit index wins; scanning downward lets the lowest overwrite.
  function automatic logic [ACT_W-1:0] lowest_set(input logic [NUM_BTN-1:0] v);
    logic [ACT_W-1:0] r;
    r = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--)
      if (v[i]) r = ACT_W'(i);
    return r;
  endfunction

endpackage

// File: rtl/action_input_if.sv
// Valid/ready action channel from the button front end to the stats stage.
interface action_input_if;
  import tamagotchi_pkg::*;

  logic             action_valid;
  logic [ACT_W-1:0] action_id;
  logic             action_ready;

  modport master (output action_valid, output action_id, input action_ready);
  modport slave  (input action_valid, input action_id, output action_ready);
endinterface

// File: rtl/action_input_debounce_bit.sv
// One button lane: 2-flop synchroniser, stability counter, rising-edge detect.
module debounce_bit #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic press
);
  localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 16'd1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt;
  logic          level_d;

  // Bring the asynchronous button level into the clock domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], btn};
  end

  // Flip the debounced level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (sync_q[1] == level) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      level <= ~level;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Delayed level for press-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_d <= 1'b0;
    else       level_d <= level;
  end

  assign press = level & ~level_d;
endmodule

// File: rtl/action_input.sv
// Button front end: debounced levels, sticky press latch, one-at-a-time action
// offer with cooldown. Optional auto-repeat enabled by ACTION_AUTOREPEAT_EN.
module action_input
  import tamagotchi_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50_000,
  parameter logic [23:0] COOLDOWN_CYCLES = 24'd10_000_000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd5_000_000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_BTN-1:0]   buttons,
  action_input_if.master       act,
  output logic [NUM_BTN-1:0]   held,
  output logic                 busy
);
  logic [NUM_BTN-1:0] press;
  logic [NUM_BTN-1:0] pending;
  logic [NUM_BTN-1:0] rpt_set;
  logic [NUM_BTN-1:0] clr;
  state_t             state, state_nxt;
  logic [ACT_W-1:0]   id_q, id_nxt;
  logic [23:0]        cd_q, cd_nxt;
  logic               accept;

  debounce_bit #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db [NUM_BTN-1:0] (
    .clk   (clk),
    .reset (reset),
    .btn   (buttons),
    .level (held),
    .press (press)
  );

`ifdef ACTION_AUTOREPEAT_EN
  logic [23:0] rpt_cnt;
  logic        rpt_hit;

  assign rpt_hit = (held != '0) && (press == '0) && (rpt_cnt == REPEAT_CYCLES - 24'd1);
  assign rpt_set = rpt_hit ? held : '0;

  // Shared repeat timer: runs while anything is held, restarts on any new press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                              rpt_cnt <= '0;
    else if (held == '0 || press != '0)     rpt_cnt <= '0;
    else if (rpt_hit)                       rpt_cnt <= '0;
    else                                    rpt_cnt <= rpt_cnt + 24'd1;
  end
`else
  assign rpt_set = '0;
`endif

  assign clr = accept ? (NUM_BTN'(1) << id_q) : '0;

  // Sticky press latch; a new press beats a same-cycle acceptance clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr) | press | rpt_set;
  end

  // FSM state, offered id and cooldown counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      id_q  <= '0;
      cd_q  <= '0;
    end else begin
      state <= state_nxt;
      id_q  <= id_nxt;
      cd_q  <= cd_nxt;
    end
  end

  // Next-state: pick lowest pending in IDLE, hold the offer until ready, then cool down.
  always_comb begin
    state_nxt = state;
    id_nxt    = id_q;
    cd_nxt    = cd_q;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending != '0) begin
          id_nxt    = lowest_set(pending);
          state_nxt = ST_OFFER;
        end
      end
      ST_OFFER: begin
        if (act.action_ready) begin
          accept = 1'b1;
          if (COOLDOWN_CYCLES == 24'd0) begin
            state_nxt = ST_IDLE;
          end else begin
            cd_nxt    = COOLDOWN_CYCLES;
            state_nxt = ST_COOLDOWN;
          end
        end
      end
      ST_COOLDOWN: begin
        cd_nxt = cd_q - 24'd1;
        if (cd_q <= 24'd1) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign act.action_valid = (state == ST_OFFER);
  assign act.action_id    = id_q;
  assign busy             = (state != ST_IDLE);
endmodule

// File: tb/tb_action_input.sv
// Directed bench for action_input (DEBOUNCE=4, COOLDOWN=8, REPEAT=20).
module tb_action_input;
  import tamagotchi_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] buttons;
  logic [7:0] held;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  action_input_if ai();

  action_input #(
    .DEBOUNCE_CYCLES(16'd4),
    .COOLDOWN_CYCLES(24'd8),
    .REPEAT_CYCLES  (24'd20)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .buttons (buttons),
    .act     (ai),
    .held    (held),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input int bound, output bit ok);
    ok = 1'b0;
    for (int t = 0; t < bound; t++) begin
      if (ai.action_valid) begin
        ok = 1'b1;
        break;
      end
      step(1);
    end
  endtask

  initial begin
    bit ok;
    int cnt;

    reset = 1'b1;
    buttons = '0;
    ai.action_ready = 1'b0;
    step(3);
    chk("rst_valid", ai.action_valid, 0);
    chk("rst_id",    ai.action_id, 0);
    chk("rst_held",  held, 0);
    chk("rst_busy",  busy, 0);
    reset = 1'b0;
    step(2);

    // 1: single press, latency through sync + debounce + pending + offer
    buttons = 8'h01;
    step(5);
    chk("t1_held_early", held, 8'h00);
    step(1);
    chk("t1_held", held, 8'h01);
    step(1);
    chk("t1_pending", dut.pending, 8'h01);
    chk("t1_valid_early", ai.action_valid, 0);
    step(1);
    chk("t1_valid", ai.action_valid, 1);
    chk("t1_id", ai.action_id, 0);
    ai.action_ready = 1'b1;
    step(1);
    ai.action_ready = 1'b0;
    chk("t1_after_acc_valid", ai.action_valid, 0);
    chk("t1_after_acc_busy", busy, 1);
    buttons = '0;
    step(20);
    chk("t1_idle", busy, 0);
    chk("t1_released", held, 0);

    // 2: 2-cycle glitch is rejected
    buttons = 8'h08;
    step(2);
    buttons = '0;
    cnt = 0;
    for (int t = 0; t < 20; t++) begin
      if (ai.action_valid) cnt++;
      step(1);
    end
    chk("t2_valid_cnt", cnt, 0);
    chk("t2_held", held, 0);
    chk("t2_pending", dut.pending, 0);

    // 3: simultaneous presses, priority, cooldown length
    ai.action_ready = 1'b1;
    buttons = 8'h24;
    wait_valid(20, ok);
    chk("t3_first_to", ok, 1);
    chk("t3_first_id", ai.action_id, 2);
    step(1);
    cnt = 0;
    for (int t = 0; t < 40; t++) begin
      if (ai.action_valid) break;
      if (busy) cnt++;
      step(1);
    end
    chk("t3_cooldown", cnt, 8);
    chk("t3_second_valid", ai.action_valid, 1);
    chk("t3_second_id", ai.action_id, 5);
    step(1);
    chk("t3_second_acc", ai.action_valid, 0);
    ai.action_ready = 1'b0;
    buttons = '0;
    step(30);
    chk("t3_idle", busy, 0);

    // 4: backpressure holds the offer stable
    buttons = 8'h02;
    wait_valid(20, ok);
    chk("t4_to", ok, 1);
    buttons = '0;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      if (!(ai.action_valid === 1'b1 && ai.action_id === 3'd1)) cnt++;
      step(1);
    end
    chk("t4_stable_bad", cnt, 0);
    chk("t4_pending", dut.pending, 8'h02);
    ai.action_ready = 1'b1;
    step(1);
    ai.action_ready = 1'b0;
    chk("t4_acc_valid", ai.action_valid, 0);
    chk("t4_acc_busy", busy, 1);
    chk("t4_acc_pending", dut.pending, 0);
    step(30);

    // 5: async reset mid-offer, then a button held through reset
    buttons = 8'h01;
    wait_valid(20, ok);
    chk("t5_to", ok, 1);
    reset = 1'b1;
    #1;
    chk("t5_rst_valid", ai.action_valid, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_pending", dut.pending, 0);
    chk("t5_rst_held", held, 0);
    buttons = '0;
    step(2);
    reset = 1'b0;
    cnt = 0;
    for (int t = 0; t < 30; t++) begin
      if (ai.action_valid) cnt++;
      step(1);
    end
    chk("t5_no_action", cnt, 0);
    reset = 1'b1;
    buttons = 8'h01;
    step(3);
    reset = 1'b0;
    wait_valid(20, ok);
    chk("t5_held_thru_to", ok, 1);
    chk("t5_held_thru_id", ai.action_id, 0);
    ai.action_ready = 1'b1;
    step(1);
    ai.action_ready = 1'b0;
    buttons = '0;
    step(30);

    // 6: long hold; auto-repeat only when built in
    ai.action_ready = 1'b1;
    buttons = 8'h10;
    cnt = 0;
    for (int t = 0; t < 75; t++) begin
      if (ai.action_valid) begin
        cnt++;
        chk("t6_id", ai.action_id, 4);
      end
      step(1);
    end
    buttons = '0;
    for (int t = 0; t < 30; t++) begin
      if (ai.action_valid) cnt++;
      step(1);
    end
    ai.action_ready = 1'b0;
`ifdef ACTION_AUTOREPEAT_EN
    chk("t6_repeat_acc", (cnt >= 2), 1);
`else
    chk("t6_single_acc", cnt, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
